// File: rtl/mem_bus_arbiter_if.sv
// CPU/memory-side signal bundle for mem_bus_arbiter: the fetch port, the load/store port and the memory port.
// The slave modport is the arbiter's view; the master modport is the CPU and memory side.
interface mem_bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_zext;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_misalign;
    logic        bus_err;
    logic        stall;

    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_zext, d_addr, d_wdata,
               mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, d_misalign, bus_err, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_zext, d_addr, d_wdata,
               mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, d_misalign, bus_err, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, with byte lanes and load extension.
// Optional MEM_TIMEOUT_EN: abort an access with bus_err after TIMEOUT_CYCLES cycles without mem_ready.
//
// state | meaning
// IDLE  | arbitrate; the cycle after RESP is a cool-down in which no grant is made
// FETCH | instruction word read in progress, waiting for mem_ready
// DATA  | load/store in progress, waiting for mem_ready
// RESP  | one-cycle ack to the granted requester
module mem_bus_arbiter #(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic             clk,
    input logic             rst,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  burst_cnt, burst_cnt_nx;
    logic        cool, cool_nx;
    logic [1:0]  r_size, r_size_nx;
    logic        r_zext, r_zext_nx;
    logic [1:0]  r_lo, r_lo_nx;
    logic        if_ack_q, if_ack_nx, d_ack_q, d_ack_nx;
    logic        mis_q, mis_nx, err_q, err_nx;
    logic        mem_en_q, mem_en_nx;
    logic [3:0]  mem_we_q, mem_we_nx;
    logic [29:0] mem_addr_q, mem_addr_nx;
    logic [31:0] mem_wdata_q, mem_wdata_nx;
    logic [31:0] if_rdata_q, if_rdata_nx, d_rdata_q, d_rdata_nx;
    logic        abort;
    logic        both_req;
    logic        unused_addr;

    assign unused_addr = ^bus.if_addr[1:0];

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    return lo != 2'b00;
            2'd1:    return lo[0];
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    return 4'b1111;
            2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b0001 << lo;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] w);
        case (sz)
            2'd0:    return w;
            2'd1:    return {2{w[15:0]}};
            default: return {4{w[7:0]}};
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lo, input logic zext);
        logic [31:0] sh;
        sh = w >> {lo, 3'b000};
        case (sz)
            2'd1:    return zext ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            2'd2:    return zext ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
            default: return w;
        endcase
    endfunction

`ifdef MEM_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo;

    // Reloaded every IDLE cycle so it is fresh on entry to FETCH/DATA.
    always_ff @(posedge clk) begin
        if (rst)                tmo <= '0;
        else if (state == IDLE) tmo <= TW'(TIMEOUT_CYCLES - 1);
        else if (tmo != '0)     tmo <= tmo - 1'b1;
    end

    assign abort = ~bus.mem_ready & (tmo == '0);
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign abort      = 1'b0;
`endif

    assign both_req = bus.if_req & bus.d_req;

    always_comb begin
        state_nx     = state;
        burst_cnt_nx = burst_cnt;
        cool_nx      = 1'b0;
        r_size_nx    = r_size;
        r_zext_nx    = r_zext;
        r_lo_nx      = r_lo;
        if_ack_nx    = 1'b0;
        d_ack_nx     = 1'b0;
        mis_nx       = 1'b0;
        err_nx       = 1'b0;
        mem_en_nx    = mem_en_q;
        mem_we_nx    = mem_we_q;
        mem_addr_nx  = mem_addr_q;
        mem_wdata_nx = mem_wdata_q;
        if_rdata_nx  = if_rdata_q;
        d_rdata_nx   = d_rdata_q;
        case (state)
            IDLE: begin
                if (!cool && bus.d_req && !(both_req && burst_cnt == 4'(MAX_DATA_BURST))) begin
                    if (bus.if_req) burst_cnt_nx = burst_cnt + 1'b1;
                    r_size_nx = bus.d_size;
                    r_zext_nx = bus.d_zext;
                    r_lo_nx   = bus.d_addr[1:0];
                    if (misaligned(bus.d_size, bus.d_addr[1:0])) begin
                        state_nx   = RESP;
                        d_ack_nx   = 1'b1;
                        mis_nx     = 1'b1;
                        d_rdata_nx = '0;
                    end else begin
                        state_nx     = DATA;
                        mem_en_nx    = 1'b1;
                        mem_addr_nx  = bus.d_addr[31:2];
                        mem_we_nx    = bus.d_we ? lanes(bus.d_size, bus.d_addr[1:0]) : 4'b0000;
                        mem_wdata_nx = replicate(bus.d_size, bus.d_wdata);
                    end
                end else if (!cool && bus.if_req) begin
                    burst_cnt_nx = '0;
                    state_nx     = FETCH;
                    mem_en_nx    = 1'b1;
                    mem_addr_nx  = bus.if_addr[31:2];
                    mem_we_nx    = 4'b0000;
                end
            end
            FETCH: begin
                if (bus.mem_ready || abort) begin
                    state_nx    = RESP;
                    mem_en_nx   = 1'b0;
                    if_ack_nx   = 1'b1;
                    err_nx      = abort;
                    if_rdata_nx = abort ? 32'h0 : bus.mem_rdata;
                end
            end
            DATA: begin
                if (bus.mem_ready || abort) begin
                    state_nx   = RESP;
                    mem_en_nx  = 1'b0;
                    d_ack_nx   = 1'b1;
                    err_nx     = abort;
                    d_rdata_nx = abort ? 32'h0 : extract(bus.mem_rdata, r_size, r_lo, r_zext);
                end
            end
            default: begin
                state_nx  = IDLE;
                mem_en_nx = 1'b0;
                cool_nx   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            cool        <= 1'b0;
            r_size      <= '0;
            r_zext      <= 1'b0;
            r_lo        <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            mis_q       <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state       <= state_nx;
            burst_cnt   <= burst_cnt_nx;
            cool        <= cool_nx;
            r_size      <= r_size_nx;
            r_zext      <= r_zext_nx;
            r_lo        <= r_lo_nx;
            if_ack_q    <= if_ack_nx;
            d_ack_q     <= d_ack_nx;
            mis_q       <= mis_nx;
            err_q       <= err_nx;
            mem_en_q    <= mem_en_nx;
            mem_we_q    <= mem_we_nx;
            mem_addr_q  <= mem_addr_nx;
            mem_wdata_q <= mem_wdata_nx;
            if_rdata_q  <= if_rdata_nx;
            d_rdata_q   <= d_rdata_nx;
        end
    end

    assign bus.if_ack     = if_ack_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.d_misalign = mis_q;
    assign bus.bus_err    = err_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.stall      = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: loads, stores, misalignment, fairness, reset and timeout.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.MAX_DATA_BURST(4), .TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drives one data request and records what the memory side saw and what came back.
    task automatic data_access(input logic we, input logic [1:0] size, input logic zext,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata,
                               output logic saw_en, output logic [3:0] we_o,
                               output logic [29:0] addr_o, output logic [31:0] wdata_o,
                               output logic [31:0] rdata_o, output logic mis_o, output int lat);
        saw_en = 1'b0; we_o = '0; addr_o = '0; wdata_o = '0; rdata_o = '1; mis_o = 1'bx; lat = -1;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size; bus.d_zext = zext;
        bus.d_addr = addr; bus.d_wdata = wdata; bus.mem_rdata = rdata; bus.mem_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (bus.mem_en && !saw_en) begin
                saw_en = 1'b1; we_o = bus.mem_we; addr_o = bus.mem_addr; wdata_o = bus.mem_wdata;
            end
            if (bus.d_ack) begin
                rdata_o = bus.d_rdata; mis_o = bus.d_misalign; lat = c;
                break;
            end
        end
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_size = 0;
        bus.d_zext = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.if_ack, bus.d_ack, bus.d_misalign, bus.bus_err, bus.mem_en, bus.mem_we} !== 9'h0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 0",
                     {bus.if_ack, bus.d_ack, bus.d_misalign, bus.bus_err, bus.mem_en, bus.mem_we});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 126'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h required 0",
                     {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.mem_en !== 1'b0 || bus.stall !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet: mem_en=%b stall=%b required 0 0", bus.mem_en, bus.stall);
        end
    endtask

    task automatic test_word_load();
        logic en, mis; logic [3:0] we; logic [29:0] ad; logic [31:0] wd, rd; int lat;
        data_access(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, en, we, ad, wd, rd, mis, lat);
        n_cmp++;
        if (en !== 1'b1 || ad !== 30'h40 || we !== 4'b0000) begin
            n_err++;
            $display("FAIL word_load_bus: en=%b addr=%h we=%b required 1 40 0000", en, ad, we);
        end
        n_cmp++;
        if (lat != 2 || rd !== 32'hDEADBEEF || mis !== 1'b0) begin
            n_err++;
            $display("FAIL word_load_ack: lat=%0d rdata=%h mis=%b required 2 deadbeef 0", lat, rd, mis);
        end
    endtask

    task automatic test_sub_word_loads();
        logic en, mis; logic [3:0] we; logic [29:0] ad; logic [31:0] wd, rd; int lat;
        logic [1:0]  sz_t [5];
        logic        zx_t [5];
        logic [31:0] ad_t [5];
        logic [31:0] ex_t [5];
        sz_t = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd2};
        zx_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ad_t = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
        ex_t = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000034};
        for (int i = 0; i < 5; i++) begin
            data_access(1'b0, sz_t[i], zx_t[i], ad_t[i], 32'h0, 32'h80FF1234,
                        en, we, ad, wd, rd, mis, lat);
            n_cmp++;
            if (rd !== ex_t[i] || mis !== 1'b0 || we !== 4'b0000 || ad !== 30'h40) begin
                n_err++;
                $display("FAIL subword_load[%0d]: rdata=%h mis=%b we=%b addr=%h required %h 0 0000 40",
                         i, rd, mis, we, ad, ex_t[i]);
            end
        end
    endtask

    task automatic test_stores();
        logic en, mis; logic [3:0] we; logic [29:0] ad; logic [31:0] wd, rd; int lat;
        logic [1:0]  sz_t [5];
        logic [31:0] ad_t [5];
        logic [31:0] di_t [5];
        logic [3:0]  we_t [5];
        logic [31:0] wx_t [5];
        sz_t = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
        ad_t = '{32'h300, 32'h202, 32'h200, 32'h201, 32'h203};
        di_t = '{32'h12345678, 32'h0000ABCD, 32'h0000ABCD, 32'h0000005A, 32'h000001C7};
        we_t = '{4'b1111, 4'b1100, 4'b0011, 4'b0010, 4'b1000};
        wx_t = '{32'h12345678, 32'hABCDABCD, 32'hABCDABCD, 32'h5A5A5A5A, 32'hC7C7C7C7};
        for (int i = 0; i < 5; i++) begin
            data_access(1'b1, sz_t[i], 1'b0, ad_t[i], di_t[i], 32'h0, en, we, ad, wd, rd, mis, lat);
            n_cmp++;
            if (en !== 1'b1 || we !== we_t[i] || wd !== wx_t[i] || ad !== ad_t[i][31:2] || lat != 2) begin
                n_err++;
                $display("FAIL store[%0d]: en=%b we=%b wdata=%h addr=%h lat=%0d required 1 %b %h %h 2",
                         i, en, we, wd, ad, lat, we_t[i], wx_t[i], ad_t[i][31:2]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic en, mis; logic [3:0] we; logic [29:0] ad; logic [31:0] wd, rd; int lat;
        logic        wr_t [3];
        logic [1:0]  sz_t [3];
        logic [31:0] ad_t [3];
        wr_t = '{1'b0, 1'b0, 1'b1};
        sz_t = '{2'd1, 2'd3, 2'd0};
        ad_t = '{32'h101, 32'h100, 32'h102};
        for (int i = 0; i < 3; i++) begin
            data_access(wr_t[i], sz_t[i], 1'b0, ad_t[i], 32'hFFFFFFFF, 32'h55AA55AA,
                        en, we, ad, wd, rd, mis, lat);
            n_cmp++;
            if (en !== 1'b0 || mis !== 1'b1 || rd !== 32'h0 || lat != 1) begin
                n_err++;
                $display("FAIL misalign[%0d]: mem_en_seen=%b mis=%b rdata=%h lat=%0d required 0 1 0 1",
                         i, en, mis, rd, lat);
            end
        end
    endtask

    task automatic test_fetch();
        logic [29:0] ad = '1; logic [3:0] we = '1; logic [31:0] rd = '0;
        logic seen = 1'b0, dack = 1'b0; int lat = -1;
        bus.if_req = 1'b1; bus.if_addr = 32'h400; bus.mem_rdata = 32'h00112233; bus.mem_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (bus.mem_en && !seen) begin seen = 1'b1; ad = bus.mem_addr; we = bus.mem_we; end
            if (bus.d_ack) dack = 1'b1;
            if (bus.if_ack) begin rd = bus.if_rdata; lat = c; break; end
        end
        bus.if_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ad !== 30'h100 || we !== 4'b0000 || rd !== 32'h00112233 || lat != 2 || dack !== 1'b0) begin
            n_err++;
            $display("FAIL fetch: addr=%h we=%b rdata=%h lat=%0d d_ack=%b required 100 0000 00112233 2 0",
                     ad, we, rd, lat, dack);
        end
    endtask

    task automatic test_wait_and_hold();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_zext = 1'b0;
        bus.d_addr = 32'h108; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 30'h42 || bus.stall !== 1'b1) begin
            n_err++;
            $display("FAIL wait_enter: mem_en=%b addr=%h stall=%b required 1 42 1",
                     bus.mem_en, bus.mem_addr, bus.stall);
        end
        bus.d_addr = 32'h503; bus.d_size = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 30'h42 || bus.d_ack !== 1'b0) begin
            n_err++;
            $display("FAIL wait_hold: mem_en=%b addr=%h d_ack=%b required 1 42 0",
                     bus.mem_en, bus.mem_addr, bus.d_ack);
        end
        bus.mem_rdata = 32'hCAFEF00D; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'hCAFEF00D || bus.mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL wait_done: d_ack=%b rdata=%h mem_en=%b required 1 cafef00d 0",
                     bus.d_ack, bus.d_rdata, bus.mem_en);
        end
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_fairness();
        byte got [6];
        byte exp_order [6];
        int  n = 0;
        exp_order = '{"D", "D", "D", "D", "F", "D"};
        for (int i = 0; i < 6; i++) got[i] = "-";
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = 32'h10;
        bus.mem_rdata = 32'h13579BDF; bus.mem_ready = 1'b1;
        for (int c = 0; c < 80 && n < 6; c++) begin
            @(posedge clk); #1;
            if (bus.d_ack)  begin got[n] = "D"; n++; end
            else if (bus.if_ack) begin got[n] = "F"; n++; end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got[i] !== exp_order[i]) begin
                n_err++;
                $display("FAIL fairness[%0d]: got %c required %c", i, got[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic acked = 1'b0, en_seen = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd0; bus.d_addr = 32'h104;
        bus.d_wdata = 32'hA5A5A5A5; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 4'b1111) begin
            n_err++;
            $display("FAIL rst_mid_enter: mem_en=%b we=%b required 1 1111", bus.mem_en, bus.mem_we);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.if_ack, bus.d_ack, bus.d_misalign, bus.bus_err, bus.mem_en, bus.mem_we,
             bus.mem_addr, bus.mem_wdata, bus.d_rdata, bus.if_rdata} !== 135'h0) begin
            n_err++;
            $display("FAIL rst_mid_clear: outputs %h required 0",
                     {bus.if_ack, bus.d_ack, bus.d_misalign, bus.bus_err, bus.mem_en, bus.mem_we,
                      bus.mem_addr, bus.mem_wdata, bus.d_rdata, bus.if_rdata});
        end
        rst = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.d_ack) acked = 1'b1;
            if (bus.mem_en) en_seen = 1'b1;
        end
        n_cmp++;
        if (acked !== 1'b0 || en_seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_abandon: d_ack_seen=%b mem_en_seen=%b required 0 0", acked, en_seen);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd = '1; logic err = 1'b0; int lat = -1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = 32'h10C;
        bus.mem_rdata = 32'h77777777; bus.mem_ready = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.bus_err) err = 1'b1;
            if (bus.d_ack) begin rd = bus.d_rdata; lat = c; break; end
        end
        bus.d_req = 1'b0;
`ifdef MEM_TIMEOUT_EN
        n_cmp++;
        if (lat != 9 || err !== 1'b1 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL timeout_abort: lat=%0d bus_err=%b rdata=%h required 9 1 0", lat, err, rd);
        end
`else
        n_cmp++;
        if (lat != -1 || err !== 1'b0 || bus.mem_en !== 1'b1) begin
            n_err++;
            $display("FAIL no_timeout: ack_lat=%0d bus_err=%b mem_en=%b required -1 0 1",
                     lat, err, bus.mem_en);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_sub_word_loads();
        test_stores();
        test_misaligned();
        test_fetch();
        test_wait_and_hold();
        test_fairness();
        test_reset_mid_access();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
